// File: rtl/fetch_queue_if.sv
// Fetch-queue bundle: fetch control inputs, instruction-memory request/response port,
// and the decode-side queue head. The master modport is the fetch unit itself.
interface fetch_queue_if #(
    parameter int XLEN = 32
) ();
    logic            stall;
    logic            redirect_valid;
    logic [XLEN-1:0] redirect_pc;
    logic            req_valid;
    logic [XLEN-1:0] req_pc;
    logic            req_ready;
    logic            rsp_valid;
    logic [XLEN-1:0] rsp_instr;
    logic            out_valid;
    logic [XLEN-1:0] out_pc;
    logic [XLEN-1:0] out_instr;
    logic            out_ready;

    modport master (
        input  stall, redirect_valid, redirect_pc, req_ready, rsp_valid, rsp_instr, out_ready,
        output req_valid, req_pc, out_valid, out_pc, out_instr
    );

    modport slave (
        output stall, redirect_valid, redirect_pc, req_ready, rsp_valid, rsp_instr, out_ready,
        input  req_valid, req_pc, out_valid, out_pc, out_instr
    );
endinterface

// File: rtl/fetch_queue_unit.sv
// Instruction fetch unit: single-outstanding memory requests feeding a DEPTH-entry queue.
// Define FETCH_PERF_CNT_EN to add redirect_count / empty_stall_count performance counters.
module fetch_queue_unit #(
    parameter int              XLEN     = 32,
    parameter int              DEPTH    = 4,
    parameter logic [XLEN-1:0] RESET_PC = '0,
    parameter int unsigned     PC_INC   = 4
) (
    input  logic          clk,
    input  logic          reset_n,
    fetch_queue_if.master bus
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0]   redirect_count,
    output logic [31:0]   empty_stall_count
`endif
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef enum logic [1:0] {IDLE, FETCH, DRAIN} state_t;

    state_t           state;
    logic [XLEN-1:0]  fetch_pc;
    logic [XLEN-1:0]  pending_pc;
    logic             outstanding;
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    logic [XLEN-1:0]  pc_mem    [DEPTH];
    logic [XLEN-1:0]  instr_mem [DEPTH];

    logic redirect;
    logic issue;
    logic accept;
    logic push;
    logic pop;

    // Issue looks only at registered occupancy, so a pop from a full queue
    // cannot open a slot for a request in the same cycle.
    assign redirect = bus.redirect_valid;
    assign issue    = (state == FETCH) && !bus.stall && !outstanding && !redirect
                      && (count < CNT_W'(DEPTH));
    assign accept   = issue && bus.req_ready;
    assign push     = (state == FETCH) && outstanding && bus.rsp_valid && !redirect;
    assign pop      = (count != '0) && bus.out_ready;

    assign bus.req_valid = issue;
    assign bus.req_pc    = fetch_pc;
    assign bus.out_valid = (count != '0);
    assign bus.out_pc    = pc_mem[rd_ptr];
    assign bus.out_instr = instr_mem[rd_ptr];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= IDLE;
            fetch_pc    <= RESET_PC;
            outstanding <= 1'b0;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count       <= '0;
        end else if (redirect) begin
            fetch_pc <= bus.redirect_pc;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            // A response landing in the redirect cycle is the stale one; no drain needed.
            if (outstanding && !bus.rsp_valid) begin
                state <= DRAIN;
            end else begin
                state       <= FETCH;
                outstanding <= 1'b0;
            end
        end else begin
            case (state)
                IDLE: state <= FETCH;
                FETCH: begin
                    if (accept) begin
                        fetch_pc    <= fetch_pc + XLEN'(PC_INC);
                        outstanding <= 1'b1;
                    end else if (push) begin
                        outstanding <= 1'b0;
                    end
                end
                DRAIN: begin
                    if (bus.rsp_valid) begin
                        outstanding <= 1'b0;
                        state       <= FETCH;
                    end
                end
                default: state <= IDLE;
            endcase
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            count <= count + CNT_W'(push) - CNT_W'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (accept) pending_pc <= fetch_pc;
        if (push) begin
            pc_mem[wr_ptr]    <= pending_pc;
            instr_mem[wr_ptr] <= bus.rsp_instr;
        end
    end

`ifdef FETCH_PERF_CNT_EN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            redirect_count    <= '0;
            empty_stall_count <= '0;
        end else begin
            if (redirect && (redirect_count != '1)) redirect_count <= redirect_count + 32'd1;
            if (bus.out_ready && !bus.out_valid) empty_stall_count <= empty_stall_count + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_fetch_queue_unit.sv
// Bench for fetch_queue_unit: vector table, directed corner sequences, and random traffic
// checked against a queue-based reference model.
module tb_fetch_queue_unit;
    localparam int DEPTH = 4;

    logic clk;
    logic reset_n;
    int   checks;
    int   errors;

    fetch_queue_if #(.XLEN(32)) bus ();

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] redirect_count;
    logic [31:0] empty_stall_count;
`endif

    fetch_queue_unit #(
        .XLEN    (32),
        .DEPTH   (DEPTH),
        .RESET_PC(32'h0),
        .PC_INC  (4)
    ) dut (
        .clk    (clk),
        .reset_n(reset_n),
        .bus    (bus)
`ifdef FETCH_PERF_CNT_EN
        ,
        .redirect_count   (redirect_count),
        .empty_stall_count(empty_stall_count)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: fetch mode, PC, in-flight request and a queue of entries.
    int          m_mode;  // 0 idle, 1 fetching, 2 waiting for stale response
    logic [31:0] m_pc;
    logic [31:0] m_pend;
    bit          m_out;
    logic [31:0] q_pc[$];
    logic [31:0] q_in[$];

    logic        e_req_valid, e_out_valid;
    logic [31:0] e_req_pc, e_out_pc, e_out_instr;
    logic        s_req_valid, s_out_valid;
    logic [31:0] s_req_pc, s_out_pc, s_out_instr;

    bit auto_rsp;
    int rsp_max;
    bit mem_pend;
    int mem_wait;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    function automatic void model_reset();
        m_mode = 0;
        m_pc   = 32'h0;
        m_out  = 0;
        q_pc.delete();
        q_in.delete();
    endfunction

    function automatic void model_eval();
        e_req_valid = (m_mode == 1) && !bus.stall && !m_out && !bus.redirect_valid
                      && (q_pc.size() < DEPTH);
        e_req_pc    = m_pc;
        e_out_valid = (q_pc.size() != 0);
        e_out_pc    = e_out_valid ? q_pc[0] : 32'h0;
        e_out_instr = e_out_valid ? q_in[0] : 32'h0;
    endfunction

    function automatic void model_step();
        if (bus.redirect_valid) begin
            q_pc.delete();
            q_in.delete();
            m_pc = bus.redirect_pc;
            if (m_out && !bus.rsp_valid) m_mode = 2;
            else begin
                m_mode = 1;
                m_out  = 0;
            end
        end else if (m_mode == 0) begin
            m_mode = 1;
        end else if (m_mode == 2) begin
            if (bus.rsp_valid) begin
                m_out  = 0;
                m_mode = 1;
            end
        end else begin
            if (e_out_valid && bus.out_ready) begin
                void'(q_pc.pop_front());
                void'(q_in.pop_front());
            end
            if (m_out && bus.rsp_valid) begin
                q_pc.push_back(m_pend);
                q_in.push_back(bus.rsp_instr);
                m_out = 0;
            end else if (e_req_valid && bus.req_ready) begin
                m_pend = m_pc;
                m_pc   = m_pc + 32'd4;
                m_out  = 1;
            end
        end
    endfunction

    // One clock cycle: inputs already driven; sample and check at negedge, advance at posedge.
    task automatic cycle();
        if (auto_rsp) begin
            bus.rsp_valid = mem_pend && (mem_wait == 0);
            bus.rsp_instr = $urandom;
        end
        @(negedge clk);
        s_req_valid = bus.req_valid;
        s_req_pc    = bus.req_pc;
        s_out_valid = bus.out_valid;
        s_out_pc    = bus.out_pc;
        s_out_instr = bus.out_instr;
        model_eval();
        chk("model_req_valid", 32'(s_req_valid), 32'(e_req_valid));
        if (e_req_valid) chk("model_req_pc", s_req_pc, e_req_pc);
        chk("model_out_valid", 32'(s_out_valid), 32'(e_out_valid));
        if (e_out_valid) begin
            chk("model_out_pc", s_out_pc, e_out_pc);
            chk("model_out_instr", s_out_instr, e_out_instr);
        end
        @(posedge clk);
        model_step();
        if (e_req_valid && bus.req_ready) begin
            mem_pend = 1;
            mem_wait = int'($urandom_range(0, rsp_max));
        end else if (bus.rsp_valid) begin
            mem_pend = 0;
        end else if (mem_pend && mem_wait > 0) begin
            mem_wait--;
        end
        #1;
    endtask

    task automatic set_in(input bit st, input bit rdv, input logic [31:0] rdpc,
                          input bit rr, input bit rv, input logic [31:0] ri, input bit orr);
        bus.stall          = st;
        bus.redirect_valid = rdv;
        bus.redirect_pc    = rdpc;
        bus.req_ready      = rr;
        bus.rsp_valid      = rv;
        bus.rsp_instr      = ri;
        bus.out_ready      = orr;
    endtask

    task automatic do_reset();
        reset_n  = 1'b0;
        model_reset();
        mem_pend = 0;
        mem_wait = 0;
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;
    endtask

    typedef struct {
        bit          stall, redir;
        logic [31:0] redir_pc;
        bit          req_ready, rsp_valid;
        logic [31:0] rsp_instr;
        bit          out_ready;
        bit          e_rv;
        logic [31:0] e_rpc;
        bit          e_ov;
        logic [31:0] e_opc, e_oin;
    } vec_t;

    function automatic vec_t mk(bit rr, bit rv, logic [31:0] ri, bit orr,
                                bit erv, logic [31:0] erpc, bit eov,
                                logic [31:0] eopc, logic [31:0] eoin);
        vec_t v;
        v.stall = 0; v.redir = 0; v.redir_pc = 32'h0;
        v.req_ready = rr; v.rsp_valid = rv; v.rsp_instr = ri; v.out_ready = orr;
        v.e_rv = erv; v.e_rpc = erpc; v.e_ov = eov; v.e_opc = eopc; v.e_oin = eoin;
        return v;
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        vec_t tbl[13];
        checks   = 0;
        errors   = 0;
        auto_rsp = 0;
        rsp_max  = 0;
        set_in(0, 0, 0, 0, 0, 0, 0);
        reset_n = 1'b0;

        // Reset state, start from IDLE, sequential fetch, ready-low hold, push+pop together
        tbl[0]  = mk(1, 0, 32'h0,        1, 0, 32'h0,  0, 32'h0,  32'h0);
        tbl[1]  = mk(1, 0, 32'h0,        1, 1, 32'h0,  0, 32'h0,  32'h0);
        tbl[2]  = mk(1, 1, 32'hA0000000, 1, 0, 32'h0,  0, 32'h0,  32'h0);
        tbl[3]  = mk(0, 0, 32'h0,        0, 1, 32'h4,  1, 32'h0,  32'hA0000000);
        tbl[4]  = mk(0, 0, 32'h0,        1, 1, 32'h4,  1, 32'h0,  32'hA0000000);
        tbl[5]  = mk(0, 0, 32'h0,        1, 1, 32'h4,  0, 32'h0,  32'h0);
        tbl[6]  = mk(1, 0, 32'h0,        1, 1, 32'h4,  0, 32'h0,  32'h0);
        tbl[7]  = mk(1, 1, 32'hA0000001, 1, 0, 32'h0,  0, 32'h0,  32'h0);
        tbl[8]  = mk(1, 0, 32'h0,        1, 1, 32'h8,  1, 32'h4,  32'hA0000001);
        tbl[9]  = mk(1, 1, 32'hA0000002, 1, 0, 32'h0,  0, 32'h0,  32'h0);
        tbl[10] = mk(1, 0, 32'h0,        0, 1, 32'hC,  1, 32'h8,  32'hA0000002);
        tbl[11] = mk(1, 1, 32'hA0000003, 1, 0, 32'h0,  1, 32'h8,  32'hA0000002);
        tbl[12] = mk(0, 0, 32'h0,        0, 1, 32'h10, 1, 32'hC,  32'hA0000003);

        do_reset();
        for (int i = 0; i < 13; i++) begin
            set_in(tbl[i].stall, tbl[i].redir, tbl[i].redir_pc, tbl[i].req_ready,
                   tbl[i].rsp_valid, tbl[i].rsp_instr, tbl[i].out_ready);
            cycle();
            chk($sformatf("tbl%0d_req_valid", i), 32'(s_req_valid), 32'(tbl[i].e_rv));
            if (tbl[i].e_rv) chk($sformatf("tbl%0d_req_pc", i), s_req_pc, tbl[i].e_rpc);
            chk($sformatf("tbl%0d_out_valid", i), 32'(s_out_valid), 32'(tbl[i].e_ov));
            if (tbl[i].e_ov) begin
                chk($sformatf("tbl%0d_out_pc", i), s_out_pc, tbl[i].e_opc);
                chk($sformatf("tbl%0d_out_instr", i), s_out_instr, tbl[i].e_oin);
            end
        end

        // Fill with decode blocked: four entries, then issue stops; resume at 16
        do_reset();
        auto_rsp = 1;
        rsp_max  = 0;
        set_in(0, 0, 0, 1, 0, 0, 0);
        repeat (9) cycle();
        repeat (4) begin
            cycle();
            chk("fill_req_valid_low", 32'(s_req_valid), 32'h0);
        end
        bus.out_ready = 1;
        cycle();
        chk("full_pop_no_issue", 32'(s_req_valid), 32'h0);
        cycle();
        chk("fill_resume_valid", 32'(s_req_valid), 32'h1);
        chk("fill_resume_pc", s_req_pc, 32'h10);

        // Stall: no issue, in-flight response still queued and popped, resume sequentially
        do_reset();
        set_in(0, 0, 0, 1, 0, 0, 1);
        cycle();
        cycle();
        chk("stall_pre_pc", s_req_pc, 32'h0);
        bus.stall = 1;
        for (int i = 0; i < 5; i++) begin
            cycle();
            chk("stall_req_valid", 32'(s_req_valid), 32'h0);
            if (i == 1) begin
                chk("stall_rsp_out_valid", 32'(s_out_valid), 32'h1);
                chk("stall_rsp_out_pc", s_out_pc, 32'h0);
            end
        end
        bus.stall = 0;
        cycle();
        chk("stall_resume_valid", 32'(s_req_valid), 32'h1);
        chk("stall_resume_pc", s_req_pc, 32'h4);

        // Redirect with request for 0x8 outstanding: drain stale response, refetch 0x100
        do_reset();
        auto_rsp = 0;
        set_in(0, 0, 0, 1, 0, 0, 1);
        cycle();
        cycle();
        bus.rsp_valid = 1; bus.rsp_instr = 32'h11; cycle(); bus.rsp_valid = 0;
        cycle();
        bus.rsp_valid = 1; bus.rsp_instr = 32'h22; cycle(); bus.rsp_valid = 0;
        cycle();
        chk("redir_pre_pc", s_req_pc, 32'h8);
        bus.redirect_valid = 1; bus.redirect_pc = 32'h100;
        cycle();
        chk("redir_cycle_req_valid", 32'(s_req_valid), 32'h0);
        bus.redirect_valid = 0;
        cycle();
        chk("drain_req_valid", 32'(s_req_valid), 32'h0);
        chk("drain_out_valid", 32'(s_out_valid), 32'h0);
        bus.rsp_valid = 1; bus.rsp_instr = 32'hDEAD; cycle(); bus.rsp_valid = 0;
        chk("drain_stale_req_valid", 32'(s_req_valid), 32'h0);
        cycle();
        chk("redir_new_valid", 32'(s_req_valid), 32'h1);
        chk("redir_new_pc", s_req_pc, 32'h100);
        bus.rsp_valid = 1; bus.rsp_instr = 32'h1234; cycle(); bus.rsp_valid = 0;
        bus.req_ready = 0;
        cycle();
        chk("redir_first_out_pc", s_out_pc, 32'h100);
        chk("redir_first_out_instr", s_out_instr, 32'h1234);

        // PC wrap at top of the address space, then asynchronous reset mid-fetch
        bus.out_ready = 0;
        bus.redirect_valid = 1; bus.redirect_pc = 32'hFFFFFFFC;
        cycle();
        bus.redirect_valid = 0; bus.req_ready = 1;
        cycle();
        chk("wrap_pre_pc", s_req_pc, 32'hFFFFFFFC);
        bus.rsp_valid = 1; bus.rsp_instr = 32'h55; cycle(); bus.rsp_valid = 0;
        cycle();
        chk("wrap_valid", 32'(s_req_valid), 32'h1);
        chk("wrap_pc", s_req_pc, 32'h0);
        chk("wrap_out_valid", 32'(s_out_valid), 32'h1);
        reset_n = 1'b0;
        #1;
        chk("async_rst_req_valid", 32'(bus.req_valid), 32'h0);
        chk("async_rst_out_valid", 32'(bus.out_valid), 32'h0);
        do_reset();
        set_in(0, 0, 0, 0, 1, 32'hBAD, 1);
        cycle();
        cycle();
        bus.rsp_valid = 0;
        chk("stale_after_rst_out_valid", 32'(s_out_valid), 32'h0);
        cycle();
        chk("post_rst_req_pc", s_req_pc, 32'h0);

        // Random traffic against the reference model
        do_reset();
        auto_rsp = 1;
        rsp_max  = 2;
        for (int i = 0; i < 2000; i++) begin
            bus.stall          = ($urandom_range(0, 3) == 0);
            bus.redirect_valid = ($urandom_range(0, 15) == 0);
            bus.redirect_pc    = $urandom & 32'hFFFFFFFC;
            bus.req_ready      = ($urandom_range(0, 3) != 0);
            bus.out_ready      = ($urandom_range(0, 2) != 0);
            cycle();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
